// File: rtl/ls95_ctrl.sv
// ls95_ctrl: command-driven sequencer for a 74LS95-style 4-bit shift register.
// Accepts LOAD / SHR / SHL / ROTR commands and produces per-step register
// controls (mode, serial input, parallel inputs) plus one clock strobe per step.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   valid/ready       command handshake (accept when both high on a rising edge)
//   op, cnt, fill,din command fields (cnt: 1..3 literal, 0 means 4)
//   qa..qd            readback from the shift register outputs
//   sclk              register clock strobe, one pulse per step
//   mode, ser, pa..pd register controls (mode 1 = parallel load)
//   busy, done        controller busy; one-cycle completion pulse
module ls95_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       valid,
    output logic       ready,
    input  logic [1:0] op,
    input  logic [1:0] cnt,
    input  logic       fill,
    input  logic [3:0] din,
    input  logic       qa,
    input  logic       qb,
    input  logic       qc,
    input  logic       qd,
    output logic       sclk,
    output logic       mode,
    output logic       ser,
    output logic       pa,
    output logic       pb,
    output logic       pc,
    output logic       pd,
    output logic       busy,
    output logic       done
);

    localparam int unsigned OP_W   = 2;
    localparam int unsigned DATA_W = 4;
    localparam int unsigned STEP_W = 3;

    localparam logic [OP_W-1:0] OP_LOAD = 2'b00;
    localparam logic [OP_W-1:0] OP_SHR  = 2'b01;
    localparam logic [OP_W-1:0] OP_SHL  = 2'b10;
    localparam logic [OP_W-1:0] OP_ROTR = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_PULSE = 3'd2,
        S_HOLD  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [OP_W-1:0]     op_q, op_d;
    logic                fill_q, fill_d;
    logic [DATA_W-1:0]   din_q, din_d;
    logic [STEP_W-1:0]   steps_q, steps_d;
    logic                sclk_q, sclk_d;
    logic                mode_q, mode_d;
    logic                ser_q, ser_d;
    logic [DATA_W-1:0]   par_q, par_d;
    logic                ready_q, ready_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic                accept_c;
    logic                enter_setup_c;
    logic [OP_W-1:0]     src_op_c;
    logic                src_fill_c;
    logic [DATA_W-1:0]   src_din_c;

    // Next-state, field latching and registered-output computation
    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        fill_d        = fill_q;
        din_d         = din_q;
        steps_d       = steps_q;
        mode_d        = mode_q;
        ser_d         = ser_q;
        par_d         = par_q;
        enter_setup_c = 1'b0;
        src_op_c      = op_q;
        src_fill_c    = fill_q;
        src_din_c     = din_q;
        accept_c      = valid && ready_q && (state_q == S_IDLE);

        case (state_q)
            S_IDLE: begin
                if (accept_c) begin
                    op_d   = op;
                    fill_d = fill;
                    din_d  = din;
                    if (op == OP_LOAD) begin
                        steps_d = STEP_W'(1);
                    end else if (cnt == 2'b00) begin
                        steps_d = STEP_W'(4);
                    end else begin
                        steps_d = STEP_W'(cnt);
                    end
                    // First step is set up from the live inputs, since the
                    // latched copies only become visible after this edge.
                    src_op_c      = op;
                    src_fill_c    = fill;
                    src_din_c     = din;
                    enter_setup_c = 1'b1;
                    state_d       = S_SETUP;
                end
            end
            S_SETUP: state_d = S_PULSE;
            S_PULSE: state_d = S_HOLD;
            S_HOLD: begin
                steps_d = steps_q - STEP_W'(1);
                if (steps_q <= STEP_W'(1)) begin
                    state_d = S_DONE;
                end else begin
                    enter_setup_c = 1'b1;
                    state_d       = S_SETUP;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Step controls change only on the edge entering SETUP
        if (enter_setup_c) begin
            case (src_op_c)
                OP_LOAD: begin
                    mode_d = 1'b1;
                    par_d  = src_din_c;
                end
                OP_SHR: begin
                    mode_d = 1'b0;
                    ser_d  = src_fill_c;
                end
                OP_SHL: begin
                    // {pd,pc,pb,pa} = {fill,qd,qc,qb}: load shifted toward A
                    mode_d = 1'b1;
                    par_d  = {src_fill_c, qd, qc, qb};
                end
                OP_ROTR: begin
                    mode_d = 1'b0;
                    ser_d  = qd;
                end
                default: mode_d = mode_q;
            endcase
        end

        sclk_d  = (state_d == S_PULSE);
        busy_d  = (state_d != S_IDLE);
        // Ready rises one edge after returning to IDLE, leaving the done cycle idle
        ready_d = (state_d == S_IDLE) && (state_q != S_DONE);
        done_d  = (state_q == S_DONE);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            fill_q  <= 1'b0;
            din_q   <= '0;
            steps_q <= '0;
            sclk_q  <= 1'b0;
            mode_q  <= 1'b0;
            ser_q   <= 1'b0;
            par_q   <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            fill_q  <= fill_d;
            din_q   <= din_d;
            steps_q <= steps_d;
            sclk_q  <= sclk_d;
            mode_q  <= mode_d;
            ser_q   <= ser_d;
            par_q   <= par_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign ready = ready_q;
    assign sclk  = sclk_q;
    assign mode  = mode_q;
    assign ser   = ser_q;
    assign pa    = par_q[0];
    assign pb    = par_q[1];
    assign pc    = par_q[2];
    assign pd    = par_q[3];
    assign busy  = busy_q;
    assign done  = done_q;

endmodule
